// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants for the RTC bus controller.
// Holds the FSM state codes, default phase timings and the op encoding.
// The optional address cache is enabled with RTC_ADDR_CACHE_EN.
package rtc_pkg;

    localparam int T_PULSE_DEF = 10;
    localparam int T_GAP_DEF   = 5;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_GAP1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_GAP2 = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // True for every state that belongs to a running bus cycle.
    function automatic logic in_bus_cycle(input logic [2:0] st);
        return (st == ST_ADDR) || (st == ST_GAP1) ||
               (st == ST_DATA) || (st == ST_GAP2);
    endfunction

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// rtc_bus_ctrl_if: processor-side request/response signals plus the
// multiplexed RTC pins. The slave modport is the controller; the master
// modport is everything around it (processor port logic and RTC chip).
interface rtc_bus_ctrl_if;

    logic       act_rtc;
    logic [7:0] dir;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;

    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;

    modport slave (
        input  act_rtc, dir, write_strobe, read_strobe, out_port, ad_in,
        output rd_data, busy, done, ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );

    modport master (
        output act_rtc, dir, write_strobe, read_strobe, out_port, ad_in,
        input  rd_data, busy, done, ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );

endinterface

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable down-counter that stops at zero.
// Used for both strobe-pulse and idle-gap timing of the RTC bus cycle.
module rtc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Reload on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: turns a one-cycle processor I/O strobe into a timed
// address-phase / data-phase cycle on the multiplexed RTC bus.
// All bus outputs are registered from the next-state value so they change
// cleanly on the clock edge that enters each phase.
// Optional: define RTC_ADDR_CACHE_EN to skip the address phase when the
// register address matches the last one sent.
module rtc_bus_ctrl
    import rtc_pkg::*;
#(
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_GAP   = T_GAP_DEF,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    rtc_bus_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(T_GAP - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             op;
    logic             op_nxt;
    logic [7:0]       addr_q;
    logic [7:0]       addr_nxt;
    logic [7:0]       data_q;
    logic [7:0]       data_nxt;
    logic             accept;
    logic             cache_hit;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    logic [7:0]       rd_data_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       ad_out_q;
    logic             ad_oe_q;
    logic             cs_n_q;
    logic             rd_n_q;
    logic             wr_n_q;
    logic             a_d_q;

    assign accept = (state == ST_IDLE) && bus.act_rtc &&
                    (bus.write_strobe || bus.read_strobe);

`ifdef RTC_ADDR_CACHE_EN
    logic [7:0] cache_addr;
    logic       cache_valid;

    assign cache_hit = cache_valid && (bus.dir == cache_addr);

    // Remember the address whenever a fresh address phase is started.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_addr  <= '0;
            cache_valid <= 1'b0;
        end else if (accept && !cache_hit) begin
            cache_addr  <= bus.dir;
            cache_valid <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Request latching: write wins when both strobes arrive together.
    always_comb begin
        op_nxt   = op;
        addr_nxt = addr_q;
        data_nxt = data_q;
        if (accept) begin
            op_nxt   = bus.write_strobe ? OP_WR : OP_RD;
            addr_nxt = bus.dir;
            data_nxt = bus.out_port;
        end
    end

    // Phase sequencing: each phase reloads the timer and ends when it hits zero.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = cache_hit ? ST_DATA : ST_ADDR;
                    tmr_load  = 1'b1;
                    tmr_val   = PULSE_LOAD;
                end
            end
            ST_ADDR: begin
                if (tmr_zero) begin
                    state_nxt = ST_GAP1;
                    tmr_load  = 1'b1;
                    tmr_val   = GAP_LOAD;
                end
            end
            ST_GAP1: begin
                if (tmr_zero) begin
                    state_nxt = ST_DATA;
                    tmr_load  = 1'b1;
                    tmr_val   = PULSE_LOAD;
                end
            end
            ST_DATA: begin
                if (tmr_zero) begin
                    state_nxt = ST_GAP2;
                    tmr_load  = 1'b1;
                    tmr_val   = GAP_LOAD;
                end
            end
            ST_GAP2: begin
                if (tmr_zero) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    rtc_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    // State, request registers and registered bus outputs for the next phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op        <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            a_d_q     <= 1'b0;
            ad_oe_q   <= 1'b0;
            ad_out_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state    <= state_nxt;
            op       <= op_nxt;
            addr_q   <= addr_nxt;
            data_q   <= data_nxt;
            cs_n_q   <= !((state_nxt == ST_ADDR) || (state_nxt == ST_DATA));
            wr_n_q   <= !((state_nxt == ST_ADDR) ||
                          ((state_nxt == ST_DATA) && (op_nxt == OP_WR)));
            rd_n_q   <= !((state_nxt == ST_DATA) && (op_nxt == OP_RD));
            a_d_q    <= (state_nxt == ST_DATA);
            ad_oe_q  <= (state_nxt == ST_ADDR) ||
                        ((state_nxt == ST_DATA) && (op_nxt == OP_WR));
            if (state_nxt == ST_ADDR) begin
                ad_out_q <= addr_nxt;
            end else if ((state_nxt == ST_DATA) && (op_nxt == OP_WR)) begin
                ad_out_q <= data_nxt;
            end else begin
                ad_out_q <= '0;
            end
            busy_q   <= in_bus_cycle(state_nxt);
            done_q   <= (state_nxt == ST_DONE);
            if ((state == ST_DATA) && tmr_zero && (op == OP_RD)) begin
                rd_data_q <= bus.ad_in;
            end
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ad_out  = ad_out_q;
    assign bus.ad_oe   = ad_oe_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.rd_n    = rd_n_q;
    assign bus.wr_n    = wr_n_q;
    assign bus.a_d     = a_d_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: scoreboard bench for rtc_bus_ctrl. Each accepted request
// pushes its expected bus behaviour; a negedge monitor collects what the
// bus did and compares on every done pulse.
// The address-cache expectations follow RTC_ADDR_CACHE_EN.
module tb_rtc_bus_ctrl;

    localparam int TP = 10;
    localparam int TG = 5;

    typedef struct {
        logic       op;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] rd;
        int         lat;
        int         addr_cyc;
        int         drive_cyc;
    } sb_entry_t;

    logic clk;
    logic reset;
    rtc_bus_ctrl_if bus ();

    sb_entry_t sb[$];
    int        cyc;
    int        tests;
    int        fails;
    logic [7:0] rtc_value;
    logic [7:0] model_rd;
    logic       mc_valid;
    logic [7:0] mc_addr;

    int         acc_addr_cyc;
    int         acc_data_cyc;
    int         acc_wr_low;
    int         acc_rd_low;
    int         acc_clash;
    int         acc_busy;
    logic [7:0] acc_addr_val;
    logic [7:0] acc_data_val;

    rtc_bus_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // RTC chip model: only drives its register value while being read.
    assign bus.ad_in = (bus.a_d && !bus.rd_n) ? rtc_value : 8'hEE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearAcc();
        acc_addr_cyc = 0;
        acc_data_cyc = 0;
        acc_wr_low   = 0;
        acc_rd_low   = 0;
        acc_clash    = 0;
        acc_busy     = 0;
        acc_addr_val = 8'h00;
        acc_data_val = 8'h00;
    endtask

    // Monitor: accumulate bus activity, score it on each done pulse.
    always @(negedge clk) begin
        sb_entry_t e;
        if (!reset) begin
            if (!bus.cs_n && !bus.a_d) begin
                acc_addr_cyc++;
                acc_addr_val = bus.ad_out;
            end
            if (!bus.cs_n && bus.a_d) begin
                acc_data_cyc++;
                if (bus.ad_oe) acc_data_val = bus.ad_out;
            end
            if (!bus.wr_n) acc_wr_low++;
            if (!bus.rd_n) acc_rd_low++;
            if (bus.ad_oe && !bus.rd_n) acc_clash++;
            if (bus.busy) acc_busy++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("latency", cyc - e.drive_cyc, e.lat);
                    checkOutput("addr_cycles", acc_addr_cyc, e.addr_cyc);
                    if (e.addr_cyc != 0) checkOutput("addr_value", acc_addr_val, e.addr);
                    checkOutput("data_cycles", acc_data_cyc, TP);
                    if (e.op) checkOutput("data_value", acc_data_val, e.data);
                    checkOutput("wr_n_low", acc_wr_low, e.addr_cyc + (e.op ? TP : 0));
                    checkOutput("rd_n_low", acc_rd_low, e.op ? 0 : TP);
                    checkOutput("bus_clash", acc_clash, 0);
                    checkOutput("busy_cycles", acc_busy, e.lat - 1);
                    checkOutput("rd_data", bus.rd_data, e.rd);
                    checkOutput("busy_at_done", bus.busy, 0);
                    clearAcc();
                end
            end
        end
    end

    // Drive one strobe cycle; push an expectation when the DUT should take it.
    task automatic applyStimulus(input logic act, input logic ws, input logic rs,
                                 input logic [7:0] d, input logic [7:0] data,
                                 input bit expect_accept);
        sb_entry_t e;
        bit hit;
        @(negedge clk);
        bus.act_rtc      = act;
        bus.write_strobe = ws;
        bus.read_strobe  = rs;
        bus.dir          = d;
        bus.out_port     = data;
        if (expect_accept) begin
            hit = 1'b0;
`ifdef RTC_ADDR_CACHE_EN
            hit = mc_valid && (mc_addr == d);
            if (!hit) begin
                mc_valid = 1'b1;
                mc_addr  = d;
            end
`endif
            e.op        = ws;
            e.addr      = d;
            e.data      = data;
            if (!ws) model_rd = rtc_value;
            e.rd        = model_rd;
            e.lat       = hit ? (TP + TG + 1) : (2 * TP + 2 * TG + 1);
            e.addr_cyc  = hit ? 0 : TP;
            e.drive_cyc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.write_strobe = 1'b0;
        bus.read_strobe  = 1'b0;
        bus.act_rtc      = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checkOutput("timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bit found;
        tests = 0;
        fails = 0;
        cyc = 0;
        model_rd = 8'h00;
        mc_valid = 1'b0;
        mc_addr = 8'h00;
        rtc_value = 8'h00;
        clearAcc();
        bus.act_rtc = 1'b0;
        bus.write_strobe = 1'b0;
        bus.read_strobe = 1'b0;
        bus.dir = 8'h00;
        bus.out_port = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_cs_n", bus.cs_n, 1);
        checkOutput("rst_rd_n", bus.rd_n, 1);
        checkOutput("rst_wr_n", bus.wr_n, 1);
        checkOutput("rst_a_d", bus.a_d, 0);
        checkOutput("rst_ad_oe", bus.ad_oe, 0);
        checkOutput("rst_ad_out", bus.ad_out, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_rd_data", bus.rd_data, 0);
        reset = 1'b0;

        // Plain write, then read, then a write that must keep rd_data.
        applyStimulus(1, 1, 0, 8'h21, 8'h45, 1);
        waitIdle();
        rtc_value = 8'h59;
        applyStimulus(1, 0, 1, 8'h41, 8'h00, 1);
        waitIdle();
        applyStimulus(1, 1, 0, 8'h10, 8'h3C, 1);
        waitIdle();

        // Both strobes together: write only.
        rtc_value = 8'h66;
        applyStimulus(1, 1, 1, 8'h12, 8'h9A, 1);
        waitIdle();

        // Strobe while busy is dropped; unselected strobe is ignored.
        applyStimulus(1, 1, 0, 8'h05, 8'h11, 1);
        repeat (5) @(negedge clk);
        checkOutput("busy_mid", bus.busy, 1);
        applyStimulus(1, 1, 0, 8'h77, 8'h88, 0);
        waitIdle();
        applyStimulus(0, 1, 1, 8'h33, 8'h44, 0);
        repeat (3) @(negedge clk);
        checkOutput("busy_unselected", bus.busy, 0);
        checkOutput("cs_n_unselected", bus.cs_n, 1);

        // Reset in the middle of a write data phase.
        applyStimulus(1, 1, 0, 8'h30, 8'hA5, 1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (!bus.cs_n && bus.a_d) found = 1'b1;
        end
        checkOutput("reach_data", found, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_cs_n", bus.cs_n, 1);
        checkOutput("mid_rst_wr_n", bus.wr_n, 1);
        checkOutput("mid_rst_ad_oe", bus.ad_oe, 0);
        checkOutput("mid_rst_busy", bus.busy, 0);
        checkOutput("mid_rst_rd_data", bus.rd_data, 0);
        @(negedge clk);
        sb.delete();
        clearAcc();
        model_rd = 8'h00;
        mc_valid = 1'b0;
        reset = 1'b0;
        rtc_value = 8'hC3;
        applyStimulus(1, 0, 1, 8'h42, 8'h00, 1);
        waitIdle();

        // Repeated address: address phase skipped when the cache is built in.
        applyStimulus(1, 1, 0, 8'h22, 8'h01, 1);
        waitIdle();
        applyStimulus(1, 1, 0, 8'h22, 8'h02, 1);
        waitIdle();

        // A few random transactions.
        for (int k = 0; k < 4; k++) begin
            rtc_value = 8'($urandom_range(0, 255));
            applyStimulus(1, 1'($urandom_range(0, 1)), 1'b1,
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
            waitIdle();
        end

        repeat (40) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
